jelly_ezusbfx2_slave_fifo: RTL and testbench
============================================

Name: jelly_ezusbfx2_slave_fifo

Overview:
- Synthesizable responder for the EZ-USB FX2 synchronous slave-FIFO interface, i.e. the FX2 side of the link.
- Master-driven pins (SLWR/SLRD/SLOE/FADDR/FD) come in; EMPTY/FULL flags and read data go out.
- Two internal FIFOs bridge to comm streams:
  - the WR endpoint (master→device) feeds comm_rx;
  - comm_tx feeds the RD endpoint (device→master).
- Used as an on-chip loopback partner and verification target for the FX2 master bridge.

Parameters:
- DATA_WIDTH, 8, FD and comm data width.
- PTR_WIDTH, 4, FIFO depth = 2**PTR_WIDTH words per endpoint.
- FX2_EMPTY_NEGATIVE, 1, fx2_empty active-low when 1.
- FX2_FULL_NEGATIVE, 1, fx2_full active-low when 1.
- FX2_SLWR_NEGATIVE, 1, fx2_slwr active-low when 1.
- FX2_SLRD_NEGATIVE, 1, fx2_slrd active-low when 1.
- FX2_SLOE_NEGATIVE, 1, fx2_sloe active-low when 1.
- FX2_FADDR_RD, 2'b00, FADDR selecting the RD endpoint.
- FX2_FADDR_WR, 2'b10, FADDR selecting the WR endpoint.

Ports:
- reset  in  1  asynchronous, active-high
- clk  in  1  single clock for everything
- fx2_slwr  in  1  write strobe from master
- fx2_slrd  in  1  read strobe from master
- fx2_sloe  in  1  output enable from master
- fx2_pktend  in  1  packet end; accepted and ignored
- fx2_faddr  in  2  endpoint select
- fx2_fd_i  in  DATA_WIDTH  write data from master
- fx2_fd_o  out  DATA_WIDTH  read data to master
- fx2_fd_t  out  DATA_WIDTH  tristate control, 1 = high-Z
- fx2_empty  out  1  RD endpoint empty flag
- fx2_full  out  1  WR endpoint full flag
- comm_tx_data  in  DATA_WIDTH  data into RD endpoint
- comm_tx_valid  in  1
- comm_tx_ready  out  1
- comm_rx_data  out  DATA_WIDTH  data from WR endpoint
- comm_rx_valid  out  1
- comm_rx_ready  in  1
- err_overflow  out  1  sticky: master wrote while full
- err_underflow  out  1  sticky: master read while empty

Behaviour:
- Polarity: strobes are decoded through the *_NEGATIVE parameters into active-high internal slwr/slrd/sloe. Flags are produced active-high internally and inverted at the pins when *_NEGATIVE=1.
- FIFO structure: each FIFO has registered rd/wr pointers of PTR_WIDTH+1 bits; the extra MSB distinguishes full from empty. Count = wr_ptr - rd_ptr, modulo wrap. Storage is read asynchronously.
- Flag timing: both flags come only from registered pointers, so they change one clock after the causing edge and never combinationally from the pin inputs.
  - fx2_empty (RD endpoint): asserted when the RD FIFO count = 0.
  - fx2_full (WR endpoint): asserted when the WR FIFO count = depth.
- Master write: at the edge, if slwr && faddr==FX2_FADDR_WR:
  - WR FIFO not full: push fx2_fd_i.
  - WR FIFO full: data is dropped and err_overflow is set.
  - slwr with any other faddr is ignored.
- Master read:
  - While RD FIFO non-empty, fx2_fd_o = head word (first-word fall-through); when empty, fx2_fd_o = 0.
  - At the edge, if slrd && faddr==FX2_FADDR_RD: non-empty pops the head; empty sets err_underflow and leaves pointers unchanged.
- Bus drive: fx2_fd_t = all 0 when sloe && faddr==FX2_FADDR_RD, otherwise all 1. This is combinational from the pins, mirroring the FX2 SLOE path.
- comm_rx (FWFT): comm_rx_valid = WR FIFO not empty; comm_rx_data = head word. The WR FIFO pops when valid && ready.
- comm_tx: comm_tx_ready = RD FIFO not full. The RD FIFO pushes when valid && ready.
- Latency:
  - A master write at edge N gives comm_rx_valid=1 after edge N.
  - A comm_tx push at edge N deasserts the empty flag after edge N, with fx2_fd_o valid in the same cycle.
- Simultaneous events:
  - Push and pop in the same cycle on either FIFO: the count is unchanged and both take effect.
  - Pushes are judged against the pre-edge registered count. A master write in the cycle the WR FIFO is full is rejected even if comm pops in that cycle.
  - Likewise, a master read in the cycle the RD FIFO is empty is rejected even if comm_tx pushes in that cycle.
- Wrap-around: pointers wrap naturally; 2**(PTR_WIDTH+1) ops leave the pointers back at their start value with the data order preserved.
- Reset (any time, including mid-burst):
  - Pointers are cleared and FIFO contents are discarded.
  - Both error flags are cleared.
  - Empty flag active, full flag inactive; with default parameters fx2_empty=0, fx2_full=1.
  - comm_rx_valid=0, comm_tx_ready=1.
  - fx2_fd_o=0; fx2_fd_t follows the pins.
- Sticky errors clear only on reset.

Test Plan:
- Reset, then idle → fx2_empty=0, fx2_full=1, comm_rx_valid=0, comm_tx_ready=1, fx2_fd_t=8'hFF, err flags 0.
- Master writes 8'h11, 8'h22, 8'h33 at faddr=2'b10, comm_rx_ready=1 → comm_rx yields 11, 22, 33 in order, first valid one cycle after the first write edge.
- comm_tx pushes A5, 5A; master drives sloe=0, faddr=2'b00 → fd_t=00, fd_o=A5. Assert slrd=0 one cycle → fd_o=5A. Second pop → fx2_empty goes 0 the following cycle and fd_o=0.
- PTR_WIDTH=4, comm_rx_ready=0, master writes 17 words → full flag asserts after the 16th, the 17th is dropped, err_overflow=1. Draining returns only words 1..16.
- With the WR FIFO full and comm_rx_ready=1 in the same cycle as a master write → that write is rejected (err_overflow=1) and the count drops to 15. Also: with RD count=1, comm_tx push and master pop in the same cycle → count stays 1.
- Reset asserted mid-transfer with 5 words in each FIFO → both FIFOs empty immediately and the flags return to reset values. A stream of 40 words afterwards passes in order with no errors.

Source files
------------

// File: rtl/jelly_ezusbfx2_slave_fifo.sv
// EZ-USB FX2 synchronous slave-FIFO responder (device side of the link).
// Ports: reset/clk; FX2 pins slwr/slrd/sloe/pktend/faddr/fd_i in,
//   fd_o/fd_t/empty/full out; comm_tx (to RD endpoint), comm_rx
//   (from WR endpoint) valid/ready streams; sticky err_overflow/underflow.
module jelly_ezusbfx2_slave_fifo #(
  parameter int         DATA_WIDTH         = 8,
  parameter int         PTR_WIDTH          = 4,
  parameter logic       FX2_EMPTY_NEGATIVE = 1'b1,
  parameter logic       FX2_FULL_NEGATIVE  = 1'b1,
  parameter logic       FX2_SLWR_NEGATIVE  = 1'b1,
  parameter logic       FX2_SLRD_NEGATIVE  = 1'b1,
  parameter logic       FX2_SLOE_NEGATIVE  = 1'b1,
  parameter logic [1:0] FX2_FADDR_RD       = 2'b00,
  parameter logic [1:0] FX2_FADDR_WR       = 2'b10
) (
  input  logic                  reset,
  input  logic                  clk,

  input  logic                  fx2_slwr,
  input  logic                  fx2_slrd,
  input  logic                  fx2_sloe,
  input  logic                  fx2_pktend,
  input  logic [1:0]            fx2_faddr,
  input  logic [DATA_WIDTH-1:0] fx2_fd_i,
  output logic [DATA_WIDTH-1:0] fx2_fd_o,
  output logic [DATA_WIDTH-1:0] fx2_fd_t,
  output logic                  fx2_empty,
  output logic                  fx2_full,

  input  logic [DATA_WIDTH-1:0] comm_tx_data,
  input  logic                  comm_tx_valid,
  output logic                  comm_tx_ready,

  output logic [DATA_WIDTH-1:0] comm_rx_data,
  output logic                  comm_rx_valid,
  input  logic                  comm_rx_ready,

  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam int DEPTH = 2 ** PTR_WIDTH;

  localparam logic [PTR_WIDTH:0] PTR_ONE  = 1;
  localparam logic [PTR_WIDTH:0] CNT_FULL = {1'b1, {PTR_WIDTH{1'b0}}};

  // Packet end carries no meaning for this responder.
  logic unused_pktend;
  assign unused_pktend = fx2_pktend;

  // Pin strobes normalised to active-high.
  logic slwr;
  logic slrd;
  logic sloe;

  assign slwr = FX2_SLWR_NEGATIVE ? ~fx2_slwr : fx2_slwr;
  assign slrd = FX2_SLRD_NEGATIVE ? ~fx2_slrd : fx2_slrd;
  assign sloe = FX2_SLOE_NEGATIVE ? ~fx2_sloe : fx2_sloe;

  logic sel_wr;
  logic sel_rd;

  assign sel_wr = (fx2_faddr == FX2_FADDR_WR);
  assign sel_rd = (fx2_faddr == FX2_FADDR_RD);

  // WR endpoint: master -> comm_rx
  logic [DATA_WIDTH-1:0] wr_mem [DEPTH];
  logic [PTR_WIDTH:0]    wr_wptr;
  logic [PTR_WIDTH:0]    wr_rptr;
  logic [PTR_WIDTH:0]    wr_cnt;
  logic                  wr_is_full;
  logic                  wr_is_empty;
  logic                  wr_req;
  logic                  wr_push;
  logic                  wr_pop;

  assign wr_cnt      = wr_wptr - wr_rptr;
  assign wr_is_full  = (wr_cnt == CNT_FULL);
  assign wr_is_empty = (wr_cnt == '0);

  assign wr_req  = slwr && sel_wr;
  assign wr_push = wr_req && !wr_is_full;
  assign wr_pop  = !wr_is_empty && comm_rx_ready;

  always_ff @(posedge clk) begin
    if (wr_push) begin
      wr_mem[wr_wptr[PTR_WIDTH-1:0]] <= fx2_fd_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_wptr <= '0;
      wr_rptr <= '0;
    end else begin
      if (wr_push) begin
        wr_wptr <= wr_wptr + PTR_ONE;
      end
      if (wr_pop) begin
        wr_rptr <= wr_rptr + PTR_ONE;
      end
    end
  end

  assign comm_rx_valid = !wr_is_empty;
  assign comm_rx_data  = wr_mem[wr_rptr[PTR_WIDTH-1:0]];

  // RD endpoint: comm_tx -> master
  logic [DATA_WIDTH-1:0] rd_mem [DEPTH];
  logic [PTR_WIDTH:0]    rd_wptr;
  logic [PTR_WIDTH:0]    rd_rptr;
  logic [PTR_WIDTH:0]    rd_cnt;
  logic                  rd_is_full;
  logic                  rd_is_empty;
  logic                  rd_req;
  logic                  rd_push;
  logic                  rd_pop;

  assign rd_cnt      = rd_wptr - rd_rptr;
  assign rd_is_full  = (rd_cnt == CNT_FULL);
  assign rd_is_empty = (rd_cnt == '0);

  assign rd_req  = slrd && sel_rd;
  assign rd_pop  = rd_req && !rd_is_empty;
  assign rd_push = comm_tx_valid && !rd_is_full;

  always_ff @(posedge clk) begin
    if (rd_push) begin
      rd_mem[rd_wptr[PTR_WIDTH-1:0]] <= comm_tx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_wptr <= '0;
      rd_rptr <= '0;
    end else begin
      if (rd_push) begin
        rd_wptr <= rd_wptr + PTR_ONE;
      end
      if (rd_pop) begin
        rd_rptr <= rd_rptr + PTR_ONE;
      end
    end
  end

  assign comm_tx_ready = !rd_is_full;

  // Head word falls through; an empty FIFO presents zero, not stale data.
  assign fx2_fd_o = rd_is_empty ? '0 : rd_mem[rd_rptr[PTR_WIDTH-1:0]];

  // Drive follows the pins directly, like the FX2 SLOE path.
  assign fx2_fd_t = {DATA_WIDTH{!(sloe && sel_rd)}};

  // Flags derive only from registered pointers.
  assign fx2_empty = FX2_EMPTY_NEGATIVE ? !rd_is_empty : rd_is_empty;
  assign fx2_full  = FX2_FULL_NEGATIVE  ? !wr_is_full  : wr_is_full;

  // Sticky protocol errors, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (wr_req && wr_is_full) begin
        err_overflow <= 1'b1;
      end
      if (rd_req && rd_is_empty) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jelly_ezusbfx2_slave_fifo.sv
// Self-checking bench for jelly_ezusbfx2_slave_fifo.
// Queue-based reference model of both endpoints, directed + random stimulus.
module tb_jelly_ezusbfx2_slave_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fx2_slwr = 1'b1;
  logic       fx2_slrd = 1'b1;
  logic       fx2_sloe = 1'b1;
  logic       fx2_pktend = 1'b1;
  logic [1:0] fx2_faddr = 2'b11;
  logic [7:0] fx2_fd_i = '0;
  logic [7:0] fx2_fd_o;
  logic [7:0] fx2_fd_t;
  logic       fx2_empty;
  logic       fx2_full;
  logic [7:0] comm_tx_data = '0;
  logic       comm_tx_valid = 1'b0;
  logic       comm_tx_ready;
  logic [7:0] comm_rx_data;
  logic       comm_rx_valid;
  logic       comm_rx_ready = 1'b0;
  logic       err_overflow;
  logic       err_underflow;

  jelly_ezusbfx2_slave_fifo dut (
    .reset         (reset),
    .clk           (clk),
    .fx2_slwr      (fx2_slwr),
    .fx2_slrd      (fx2_slrd),
    .fx2_sloe      (fx2_sloe),
    .fx2_pktend    (fx2_pktend),
    .fx2_faddr     (fx2_faddr),
    .fx2_fd_i      (fx2_fd_i),
    .fx2_fd_o      (fx2_fd_o),
    .fx2_fd_t      (fx2_fd_t),
    .fx2_empty     (fx2_empty),
    .fx2_full      (fx2_full),
    .comm_tx_data  (comm_tx_data),
    .comm_tx_valid (comm_tx_valid),
    .comm_tx_ready (comm_tx_ready),
    .comm_rx_data  (comm_rx_data),
    .comm_rx_valid (comm_rx_valid),
    .comm_rx_ready (comm_rx_ready),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] FA_RD = 2'b00;
  localparam logic [1:0] FA_WR = 2'b10;
  localparam int         DEPTH = 16;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model
  logic [7:0] wq[$];
  logic [7:0] rq[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  logic [7:0] rx_seen[$];
  logic [7:0] rd_seen[$];

  // {empty pin, full pin, rx_valid, tx_ready, ovf, unf}; pins active-low
  function automatic logic [5:0] exp_status();
    return {rq.size() != 0, wq.size() != DEPTH,
            wq.size() != 0, rq.size() != DEPTH, m_ovf, m_unf};
  endfunction

  function automatic logic [5:0] dut_status();
    return {fx2_empty, fx2_full, comm_rx_valid,
            comm_tx_ready, err_overflow, err_underflow};
  endfunction

  function automatic logic [7:0] exp_fd_o();
    return (rq.size() != 0) ? rq[0] : 8'h00;
  endfunction

  // One clock of stimulus; model advances using pre-edge occupancy.
  task automatic cyc(input logic wr, input logic [1:0] fa,
                     input logic [7:0] wd, input logic rd,
                     input logic oe, input logic txv,
                     input logic [7:0] txd, input logic rxr);
    int wsz;
    int rsz;
    fx2_slwr      = ~wr;
    fx2_slrd      = ~rd;
    fx2_sloe      = ~oe;
    fx2_faddr     = fa;
    fx2_fd_i      = wd;
    comm_tx_valid = txv;
    comm_tx_data  = txd;
    comm_rx_ready = rxr;
    #1;
    wsz = wq.size();
    rsz = rq.size();
    if (rxr && wsz != 0) rx_seen.push_back(comm_rx_data);
    if (rd && fa == FA_RD && rsz != 0) rd_seen.push_back(fx2_fd_o);
    @(posedge clk);
    #1;
    if (rxr && wsz != 0) void'(wq.pop_front());
    if (wr && fa == FA_WR) begin
      if (wsz == DEPTH) m_ovf = 1'b1;
      else wq.push_back(wd);
    end
    if (rd && fa == FA_RD) begin
      if (rsz == 0) m_unf = 1'b1;
      else void'(rq.pop_front());
    end
    if (txv && rsz != DEPTH) rq.push_back(txd);
  endtask

  task automatic idle(input int n, input logic rxr);
    for (int i = 0; i < n; i++) cyc(0, 2'b11, 8'h00, 0, 0, 0, 8'h00, rxr);
  endtask

  task automatic do_reset();
    fx2_slwr = 1'b1;
    fx2_slrd = 1'b1;
    fx2_sloe = 1'b1;
    fx2_faddr = 2'b11;
    comm_tx_valid = 1'b0;
    comm_rx_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wq.delete();
    rq.delete();
    rx_seen.delete();
    rd_seen.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    idle(2, 0);
    vectors++;
    if (dut_status() !== 6'b010100) begin
      miscompares++;
      $display("FAIL reset_status got %b exp %b", dut_status(), 6'b010100);
    end
    vectors++;
    if (fx2_fd_t !== 8'hFF || fx2_fd_o !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_bus got t=%h o=%h exp t=ff o=00", fx2_fd_t, fx2_fd_o);
    end
  endtask

  task automatic test_master_write();
    logic [7:0] exp [3];
    exp = '{8'h11, 8'h22, 8'h33};
    do_reset();
    cyc(1, FA_WR, 8'h11, 0, 0, 0, 8'h00, 1);
    vectors++;
    if (comm_rx_valid !== 1'b1 || comm_rx_data !== 8'h11) begin
      miscompares++;
      $display("FAIL wr_first_latency got v=%b d=%h exp v=1 d=11",
               comm_rx_valid, comm_rx_data);
    end
    cyc(1, FA_WR, 8'h22, 0, 0, 0, 8'h00, 1);
    cyc(1, FA_WR, 8'h33, 0, 0, 0, 8'h00, 1);
    idle(3, 1);
    vectors++;
    if (rx_seen.size() != 3 || dut_status() !== exp_status()) begin
      miscompares++;
      $display("FAIL wr_count got n=%0d st=%b exp n=3 st=%b",
               rx_seen.size(), dut_status(), exp_status());
    end
    for (int i = 0; i < 3 && i < rx_seen.size(); i++) begin
      vectors++;
      if (rx_seen[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL wr_data[%0d] got %h exp %h", i, rx_seen[i], exp[i]);
      end
    end
  endtask

  task automatic test_master_read();
    do_reset();
    cyc(0, 2'b11, 8'h00, 0, 0, 1, 8'hA5, 0);
    cyc(0, 2'b11, 8'h00, 0, 0, 1, 8'h5A, 0);
    cyc(0, FA_RD, 8'h00, 0, 1, 0, 8'h00, 0);
    vectors++;
    if (fx2_fd_t !== 8'h00 || fx2_fd_o !== 8'hA5 || fx2_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_head got t=%h o=%h e=%b exp t=00 o=a5 e=1",
               fx2_fd_t, fx2_fd_o, fx2_empty);
    end
    cyc(0, FA_RD, 8'h00, 1, 1, 0, 8'h00, 0);
    vectors++;
    if (fx2_fd_o !== 8'h5A || fx2_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_second got o=%h e=%b exp o=5a e=1", fx2_fd_o, fx2_empty);
    end
    cyc(0, FA_RD, 8'h00, 1, 1, 0, 8'h00, 0);
    vectors++;
    if (fx2_fd_o !== 8'h00 || dut_status() !== 6'b010100) begin
      miscompares++;
      $display("FAIL rd_drained got o=%h st=%b exp o=00 st=010100",
               fx2_fd_o, dut_status());
    end
    vectors++;
    if (rd_seen.size() != 2 || rd_seen[0] !== 8'hA5 || rd_seen[1] !== 8'h5A) begin
      miscompares++;
      $display("FAIL rd_order got n=%0d exp a5,5a", rd_seen.size());
    end
    cyc(0, FA_WR, 8'h00, 0, 1, 0, 8'h00, 0);
    vectors++;
    if (fx2_fd_t !== 8'hFF) begin
      miscompares++;
      $display("FAIL rd_oe_wrong_addr got t=%h exp ff", fx2_fd_t);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      cyc(1, FA_WR, 8'(i), 0, 0, 0, 8'h00, 0);
      if (i == 15 || i == 16) begin
        vectors++;
        if (fx2_full !== (i == 15) || err_overflow !== 1'b0) begin
          miscompares++;
          $display("FAIL ovf_full_at_%0d got f=%b o=%b exp f=%b o=0",
                   i, fx2_full, err_overflow, i == 15);
        end
      end
    end
    vectors++;
    if (err_overflow !== 1'b1 || fx2_full !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_flag got o=%b f=%b exp o=1 f=0", err_overflow, fx2_full);
    end
    idle(20, 1);
    vectors++;
    if (rx_seen.size() != 16) begin
      miscompares++;
      $display("FAIL ovf_drain_count got %0d exp 16", rx_seen.size());
    end
    for (int i = 0; i < rx_seen.size(); i++) begin
      vectors++;
      if (rx_seen[i] !== 8'(i + 1)) begin
        miscompares++;
        $display("FAIL ovf_drain[%0d] got %h exp %h", i, rx_seen[i], 8'(i + 1));
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, FA_WR, 8'(i), 0, 0, 0, 8'h00, 0);
    cyc(1, FA_WR, 8'hEE, 0, 0, 0, 8'h00, 1);
    vectors++;
    if (err_overflow !== 1'b1 || fx2_full !== 1'b1) begin
      miscompares++;
      $display("FAIL sim_full_pop got o=%b f=%b exp o=1 f=1", err_overflow, fx2_full);
    end
    idle(18, 1);
    vectors++;
    if (rx_seen.size() != 16) begin
      miscompares++;
      $display("FAIL sim_drain_count got %0d exp 16", rx_seen.size());
    end
    for (int i = 0; i < rx_seen.size(); i++) begin
      vectors++;
      if (rx_seen[i] !== 8'(i)) begin
        miscompares++;
        $display("FAIL sim_drain[%0d] got %h exp %h", i, rx_seen[i], 8'(i));
      end
    end
    do_reset();
    cyc(0, 2'b11, 8'h00, 0, 0, 1, 8'h77, 0);
    cyc(0, FA_RD, 8'h00, 1, 1, 1, 8'h88, 0);
    vectors++;
    if (fx2_empty !== 1'b1 || fx2_fd_o !== 8'h88 || err_underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL sim_rd_pushpop got e=%b o=%h u=%b exp e=1 o=88 u=0",
               fx2_empty, fx2_fd_o, err_underflow);
    end
    cyc(0, FA_RD, 8'h00, 1, 1, 0, 8'h00, 0);
    vectors++;
    if (fx2_empty !== 1'b0 || rd_seen.size() != 2) begin
      miscompares++;
      $display("FAIL sim_rd_empty got e=%b n=%0d exp e=0 n=2", fx2_empty, rd_seen.size());
    end
    do_reset();
    cyc(0, FA_RD, 8'h00, 1, 1, 1, 8'h99, 0);
    vectors++;
    if (err_underflow !== 1'b1 || fx2_empty !== 1'b1 || fx2_fd_o !== 8'h99) begin
      miscompares++;
      $display("FAIL sim_unf_push got u=%b e=%b o=%h exp u=1 e=1 o=99",
               err_underflow, fx2_empty, fx2_fd_o);
    end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1, FA_WR, 8'(8'h40 + i), 0, 0, 1, 8'(8'h60 + i), 0);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (dut_status() !== 6'b010100 || fx2_fd_o !== 8'h00) begin
      miscompares++;
      $display("FAIL midreset got st=%b o=%h exp st=010100 o=00", dut_status(), fx2_fd_o);
    end
    #2;
    reset = 1'b0;
    wq.delete();
    rq.delete();
    rx_seen.delete();
    rd_seen.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    for (int i = 0; i < 40; i++) cyc(1, FA_WR, 8'(i), 0, 0, 0, 8'h00, 1);
    cyc(0, FA_RD, 8'h00, 0, 1, 1, 8'h00, 1);
    for (int i = 1; i < 40; i++) cyc(0, FA_RD, 8'h00, 1, 1, 1, 8'(i), 1);
    cyc(0, FA_RD, 8'h00, 1, 1, 0, 8'h00, 1);
    vectors++;
    if (rx_seen.size() != 40 || rd_seen.size() != 40 ||
        dut_status() !== 6'b010100) begin
      miscompares++;
      $display("FAIL stream_summary got rx=%0d rd=%0d st=%b exp 40 40 010100",
               rx_seen.size(), rd_seen.size(), dut_status());
    end
    for (int i = 0; i < 40; i++) begin
      if (i < rx_seen.size() && i < rd_seen.size()) begin
        vectors++;
        if (rx_seen[i] !== 8'(i) || rd_seen[i] !== 8'(i)) begin
          miscompares++;
          $display("FAIL stream[%0d] got rx=%h rd=%h exp %h",
                   i, rx_seen[i], rd_seen[i], 8'(i));
        end
      end
    end
  endtask

  task automatic test_random();
    logic       wr;
    logic       rd;
    logic       oe;
    logic       txv;
    logic       rxr;
    logic [1:0] fa;
    int         pw;
    int         pr;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      // Phases skew traffic so both FIFOs hit full and empty and wrap.
      pw = (n % 200 < 100) ? 80 : 20;
      pr = (n % 200 < 100) ? 20 : 80;
      fa = ($urandom_range(0, 9) < 5) ? FA_WR :
           (($urandom_range(0, 9) < 8) ? FA_RD : 2'(1 + 2 * $urandom_range(0, 1)));
      wr  = $urandom_range(0, 99) < pw;
      rd  = $urandom_range(0, 99) < pr;
      oe  = $urandom_range(0, 1);
      txv = $urandom_range(0, 99) < pw;
      rxr = $urandom_range(0, 99) < pr;
      cyc(wr, fa, 8'($urandom), rd, oe, txv, 8'($urandom), rxr);
      vectors++;
      if (dut_status() !== exp_status() || fx2_fd_o !== exp_fd_o() ||
          fx2_fd_t !== ((oe && fa == FA_RD) ? 8'h00 : 8'hFF)) begin
        miscompares++;
        $display("FAIL rand[%0d] got st=%b o=%h t=%h exp st=%b o=%h",
                 n, dut_status(), fx2_fd_o, fx2_fd_t, exp_status(), exp_fd_o());
      end
      if (wq.size() != 0) begin
        vectors++;
        if (comm_rx_data !== wq[0]) begin
          miscompares++;
          $display("FAIL rand_rx[%0d] got %h exp %h", n, comm_rx_data, wq[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_master_write();
    test_master_read();
    test_overflow();
    test_simultaneous();
    test_reset_midburst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
